// File: rtl/antirrebotes_pkg.sv
// antirrebotes_pkg: channel state encoding and default timing constants.
package antirrebotes_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_LOCK   = 2'd1,
        HELD         = 2'd2,
        RELEASE_LOCK = 2'd3
    } state_t;

    localparam int CLK_HZ      = 50_000_000;
    localparam int T_DEB_300MS = CLK_HZ / 1000 * 300;

endpackage

// File: rtl/antirrebotes_multi_if.sv
// antirrebotes_multi_if: raw button inputs and per-channel debounced outputs.
interface antirrebotes_multi_if #(
    parameter int N_CH = 4
);

    logic [N_CH-1:0] i_boton0;
    logic [N_CH-1:0] o_boton;
    logic [N_CH-1:0] o_press;
    logic [N_CH-1:0] o_release;
    logic [N_CH-1:0] o_repeat;

    modport master (
        output i_boton0,
        input  o_boton, o_press, o_release, o_repeat
    );

    modport slave (
        input  i_boton0,
        output o_boton, o_press, o_release, o_repeat
    );

endinterface

// File: rtl/antirrebotes_ch.sv
// antirrebotes_ch: one button channel -- synchroniser, lockout FSM, press/release pulses.
// Auto-repeat is built only when ANTIRREBOTES_AUTOREPEAT_EN is defined.
module antirrebotes_ch
    import antirrebotes_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int T_DEB       = T_DEB_300MS,
    parameter int T_RPT_FIRST = 25_000_000,
    parameter int T_RPT       = 5_000_000
)(
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_boton0,
    output logic o_boton,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam logic [CNT_W-1:0] LP_DEB_LAST = CNT_W'(T_DEB - 1);
    localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

    logic [1:0]       r_sync;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_boton, r_press, r_release;
    logic             w_boton_nxt, w_press_nxt, w_release_nxt;
    logic             w_sync, w_lock_end;

    assign w_sync     = r_sync[1];
    assign w_cnt_inc  = r_cnt + LP_ONE;
    assign w_lock_end = (r_cnt == LP_DEB_LAST);

`ifdef ANTIRREBOTES_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] LP_RPT_LAST   = CNT_W'(T_RPT_FIRST - 1);
    localparam logic [CNT_W-1:0] LP_RPT_RELOAD = CNT_W'(T_RPT_FIRST - T_RPT);
    logic r_repeat, w_repeat_nxt;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
`ifdef ANTIRREBOTES_AUTOREPEAT_EN
        w_repeat_nxt  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_state_nxt = w_sync ? PRESS_LOCK : IDLE;
                w_press_nxt = w_sync;
            end
            PRESS_LOCK: begin
                if (w_lock_end) begin
                    w_state_nxt   = w_sync ? HELD : RELEASE_LOCK;
                    w_release_nxt = !w_sync;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            HELD: begin
                if (!w_sync) begin
                    w_state_nxt   = RELEASE_LOCK;
                    w_release_nxt = 1'b1;
                end
`ifdef ANTIRREBOTES_AUTOREPEAT_EN
                // Reload so every later repeat lands T_RPT cycles after the previous one
                else if (r_cnt == LP_RPT_LAST) begin
                    w_repeat_nxt = 1'b1;
                    w_cnt_nxt    = LP_RPT_RELOAD;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
`endif
            end
            RELEASE_LOCK: begin
                if (w_lock_end) begin
                    w_state_nxt = w_sync ? PRESS_LOCK : IDLE;
                    w_press_nxt = w_sync;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_boton_nxt = (w_state_nxt == PRESS_LOCK) || (w_state_nxt == HELD);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync    <= '0;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_boton   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_boton0};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_boton   <= w_boton_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

`ifdef ANTIRREBOTES_AUTOREPEAT_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_repeat <= 1'b0;
        else        r_repeat <= w_repeat_nxt;
    end
    assign o_repeat = r_repeat;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_boton   = r_boton;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/antirrebotes_multi.sv
// antirrebotes_multi: N_CH independent push-button debouncers with press/release pulses.
// Optional auto-repeat pulses are enabled by defining ANTIRREBOTES_AUTOREPEAT_EN.
module antirrebotes_multi
    import antirrebotes_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 24,
    parameter int T_DEB       = T_DEB_300MS,
    parameter int T_RPT_FIRST = 25_000_000,
    parameter int T_RPT       = 5_000_000
)(
    input logic                 Clk,
    input logic                 Rst_n,
    antirrebotes_multi_if.slave bus
);

    logic [N_CH-1:0] w_boton, w_press, w_release, w_repeat;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        antirrebotes_ch #(
            .CNT_W       (CNT_W),
            .T_DEB       (T_DEB),
            .T_RPT_FIRST (T_RPT_FIRST),
            .T_RPT       (T_RPT)
        ) u_ch (
            .Clk       (Clk),
            .Rst_n     (Rst_n),
            .i_boton0  (bus.i_boton0[g]),
            .o_boton   (w_boton[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_repeat  (w_repeat[g])
        );
    end

    assign bus.o_boton   = w_boton;
    assign bus.o_press   = w_press;
    assign bus.o_release = w_release;
    assign bus.o_repeat  = w_repeat;

endmodule
